lcd_sequencer: RTL

LCD_SEQUENCER -- requirements
Module: lcd_sequencer

---
 rtl/lcd_pkg.sv | 44 ++++
 rtl/lcd_init_rom.sv | 17 +
 rtl/lcd_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD init/stream sequencer: ROM op codes, FSM
// states, the RAMWR command and the panel init table contents.
package lcd_pkg;

    typedef enum logic [1:0] {
        OP_CMD   = 2'b00,
        OP_DATA  = 2'b01,
        OP_DELAY = 2'b10,
        OP_END   = 2'b11
    } op_t;

    typedef struct packed {
        op_t        op;
        logic [7:0] arg;
    } rom_entry_t;

    typedef enum logic [3:0] {
        ST_RST_LOW,
        ST_RST_WAIT,
        ST_FETCH,
        ST_SEND,
        ST_WAIT_SPI,
        ST_DELAY,
        ST_STREAM,
        ST_PIX_CMD,
        ST_PIX_HI,
        ST_PIX_LO
    } state_t;

    localparam logic [7:0] RAMWR = 8'h2C;

    // Sleep-out, settle, pixel format data byte, then stream.
    function automatic rom_entry_t init_entry(input logic [31:0] idx);
        rom_entry_t e;
        case (idx)
            32'd0:   e = '{op: OP_CMD,   arg: 8'h11};
            32'd1:   e = '{op: OP_DELAY, arg: 8'd3};
            32'd2:   e = '{op: OP_DATA,  arg: 8'h55};
            default: e = '{op: OP_END,   arg: 8'h00};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Panel init table with a registered (one-cycle latency) read port.
module lcd_init_rom
    import lcd_pkg::*;
#(
    parameter int unsigned ROM_DEPTH = 64,
    parameter int unsigned AW        = $clog2(ROM_DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    output logic [9:0]    entry
);

    always_ff @(posedge clk) begin
        entry <= init_entry(32'(addr));
    end

endmodule

// File: rtl/lcd_sequencer.sv
// Drives panel reset, plays the init ROM over a byte-wide SPI sender, then
// streams RGB565 pixels as two data bytes (RAMWR first on start of frame).
module lcd_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned RST_LOW_CYCLES  = 2700,
    parameter int unsigned RST_WAIT_CYCLES = 3240000,
    parameter int unsigned DELAY_UNIT      = 27000,
    parameter int unsigned ROM_DEPTH       = 64
) (
    input  logic        clk,
    input  logic        rst,
    output logic [7:0]  spi_byte,
    output logic        spi_enable,
    input  logic        spi_ready,
    input  logic        spi_busy,
    output logic        lcd_dc,
    output logic        lcd_cs,
    output logic        lcd_rst,
    input  logic [15:0] pix_data,
    input  logic        pix_sof,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        init_done
);

    localparam int unsigned AW = $clog2(ROM_DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(ROM_DEPTH - 1);

    state_t        state;
    state_t        ret_state;
    logic [31:0]   cnt;
    logic [31:0]   dly_target;
    logic [AW-1:0] addr;
    logic          fetch_wait;
    logic [9:0]    rom_q;
    rom_entry_t    entry;
    logic [15:0]   pix_q;

    lcd_init_rom #(
        .ROM_DEPTH (ROM_DEPTH),
        .AW        (AW)
    ) u_rom (
        .clk   (clk),
        .addr  (addr),
        .entry (rom_q)
    );

    assign entry     = rom_entry_t'(rom_q);
    assign pix_ready = (state == ST_STREAM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RST_LOW;
            ret_state  <= ST_FETCH;
            cnt        <= '0;
            dly_target <= '0;
            addr       <= '0;
            fetch_wait <= 1'b1;
            lcd_rst    <= 1'b0;
            lcd_cs     <= 1'b1;
            lcd_dc     <= 1'b0;
            spi_enable <= 1'b0;
            spi_byte   <= '0;
            init_done  <= 1'b0;
            pix_q      <= '0;
        end else begin
            spi_enable <= 1'b0;
            case (state)
                ST_RST_LOW: begin
                    if (cnt == RST_LOW_CYCLES - 1) begin
                        cnt     <= '0;
                        lcd_rst <= 1'b1;
                        state   <= ST_RST_WAIT;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                ST_RST_WAIT: begin
                    if (cnt == RST_WAIT_CYCLES - 1) begin
                        cnt        <= '0;
                        addr       <= '0;
                        fetch_wait <= 1'b1;
                        state      <= ST_FETCH;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                // First cycle lets the registered ROM catch up with addr.
                ST_FETCH: begin
                    if (fetch_wait) begin
                        fetch_wait <= 1'b0;
                    end else if (entry.op == OP_END || addr == LAST_ADDR) begin
                        init_done <= 1'b1;
                        state     <= ST_STREAM;
                    end else if (entry.op == OP_DELAY) begin
                        cnt        <= '0;
                        dly_target <= 32'(entry.arg) * DELAY_UNIT;
                        state      <= ST_DELAY;
                    end else begin
                        spi_byte  <= entry.arg;
                        lcd_dc    <= (entry.op == OP_DATA);
                        ret_state <= ST_FETCH;
                        state     <= ST_SEND;
                    end
                end

                ST_DELAY: begin
                    if (cnt == dly_target) begin
                        cnt        <= '0;
                        addr       <= addr + AW'(1);
                        fetch_wait <= 1'b1;
                        state      <= ST_FETCH;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                ST_SEND: begin
                    if (!spi_busy) begin
                        spi_enable <= 1'b1;
                        lcd_cs     <= 1'b0;
                        state      <= ST_WAIT_SPI;
                    end
                end

                ST_WAIT_SPI: begin
                    if (spi_ready) begin
                        state <= ret_state;
                        if (ret_state == ST_FETCH) begin
                            addr       <= addr + AW'(1);
                            fetch_wait <= 1'b1;
                        end
                    end
                end

                ST_STREAM: begin
                    if (pix_valid) begin
                        pix_q <= pix_data;
                        state <= pix_sof ? ST_PIX_CMD : ST_PIX_HI;
                    end
                end

                ST_PIX_CMD: begin
                    spi_byte  <= RAMWR;
                    lcd_dc    <= 1'b0;
                    ret_state <= ST_PIX_HI;
                    state     <= ST_SEND;
                end

                ST_PIX_HI: begin
                    spi_byte  <= pix_q[15:8];
                    lcd_dc    <= 1'b1;
                    ret_state <= ST_PIX_LO;
                    state     <= ST_SEND;
                end

                ST_PIX_LO: begin
                    spi_byte  <= pix_q[7:0];
                    lcd_dc    <= 1'b1;
                    ret_state <= ST_STREAM;
                    state     <= ST_SEND;
                end

                default: state <= ST_RST_LOW;
            endcase
        end
    end

endmodule
